// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - writeback request, register file write and scoreboard query bundle
interface reg_wb_arbiter_if #(
    parameter int reg_sel_width = 5,
    parameter int data_width    = 32
);
    logic                     alu_req;
    logic [reg_sel_width-1:0] alu_sel;
    logic [data_width-1:0]    alu_data;
    logic                     alu_ack;
    logic                     mem_req;
    logic [reg_sel_width-1:0] mem_sel;
    logic [data_width-1:0]    mem_data;
    logic                     mem_ack;
    logic                     wr_req;
    logic [reg_sel_width-1:0] wr_sel;
    logic [data_width-1:0]    wr_data;
    logic                     issue_req;
    logic [reg_sel_width-1:0] issue_sel;
    logic [reg_sel_width-1:0] rs1_sel;
    logic [reg_sel_width-1:0] rs2_sel;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic                     idle;

    modport master (
        output alu_req, alu_sel, alu_data, mem_req, mem_sel, mem_data,
        output issue_req, issue_sel, rs1_sel, rs2_sel,
        input  alu_ack, mem_ack, wr_req, wr_sel, wr_data, rs1_busy, rs2_busy, idle
    );

    modport slave (
        input  alu_req, alu_sel, alu_data, mem_req, mem_sel, mem_data,
        input  issue_req, issue_sel, rs1_sel, rs2_sel,
        output alu_ack, mem_ack, wr_req, wr_sel, wr_data, rs1_busy, rs2_busy, idle
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin ALU/load writeback arbiter with busy-bit scoreboard
module reg_wb_arbiter #(
    parameter int reg_sel_width = 5,
    parameter int num_regs      = 2**reg_sel_width,
    parameter int data_width    = 32
) (
    input  logic            clk,
    input  logic            rst,
    reg_wb_arbiter_if.slave bus
);
    typedef enum logic {GRANT_ALU, GRANT_MEM} grant_t;

    grant_t                   last_grant, last_grant_next;
    logic                     grant_alu, grant_mem, grant_any;
    logic [reg_sel_width-1:0] win_sel;
    logic [data_width-1:0]    win_data;
    logic [num_regs-1:0]      busy, busy_next;
    logic                     wr_req_q;
    logic [reg_sel_width-1:0] wr_sel_q;
    logic [data_width-1:0]    wr_data_q;

    always_ff @(posedge clk) begin
        if (!rst) last_grant <= GRANT_MEM;
        else      last_grant <= last_grant_next;
    end

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        grant_alu       = 1'b0;
        grant_mem       = 1'b0;
        last_grant_next = last_grant;
        if (rst) begin
            if (bus.alu_req && (!bus.mem_req || last_grant == GRANT_MEM))
                grant_alu = 1'b1;
            else if (bus.mem_req)
                grant_mem = 1'b1;
        end
        if (grant_alu) last_grant_next = GRANT_ALU;
        if (grant_mem) last_grant_next = GRANT_MEM;
    end

    assign grant_any = grant_alu | grant_mem;
    assign win_sel   = grant_alu ? bus.alu_sel  : bus.mem_sel;
    assign win_data  = grant_alu ? bus.alu_data : bus.mem_data;

    // A write to register 0 is acked and consumes its turn but never reaches the port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_req_q  <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_req_q <= grant_any && (win_sel != '0);
            if (grant_any) begin
                wr_sel_q  <= win_sel;
                wr_data_q <= win_data;
            end
        end
    end

    // Set is applied after clear so an issue to the register being written keeps it busy.
    always_comb begin
        busy_next = busy;
        if (wr_req_q)
            busy_next[wr_sel_q] = 1'b0;
        if (bus.issue_req && bus.issue_sel != '0)
            busy_next[bus.issue_sel] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy <= '0;
        else      busy <= busy_next;
    end

    assign bus.alu_ack  = grant_alu;
    assign bus.mem_ack  = grant_mem;
    assign bus.wr_req   = wr_req_q;
    assign bus.wr_sel   = wr_sel_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rs1_busy = busy[bus.rs1_sel];
    assign bus.rs2_busy = busy[bus.rs2_sel];
    assign bus.idle     = (busy == '0) && !wr_req_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed vector bench for reg_wb_arbiter
module tb_reg_wb_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_wb_arbiter_if #(.reg_sel_width(5), .data_width(32)) bus ();

    reg_wb_arbiter #(.reg_sel_width(5), .num_regs(32), .data_width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ar;
        logic [4:0]  as;
        logic [31:0] ad;
        logic        mr;
        logic [4:0]  ms;
        logic [31:0] md;
        logic        ir;
        logic [4:0]  is;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_aack;
        logic        e_mack;
        logic        e_wr;
        logic [4:0]  e_sel;
        logic [31:0] e_data;
        logic        e_b1;
        logic        e_b2;
        logic        e_idle;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic ar, input logic [4:0] as, input logic [31:0] ad,
        input logic mr, input logic [4:0] ms, input logic [31:0] md,
        input logic ir, input logic [4:0] is, input logic [4:0] r1, input logic [4:0] r2,
        input logic ea, input logic em, input logic ew, input logic [4:0] es,
        input logic [31:0] ed, input logic b1, input logic b2, input logic ei);
        vec_t v;
        v.rst = r;   v.ar = ar; v.as = as; v.ad = ad;
        v.mr = mr;   v.ms = ms; v.md = md;
        v.ir = ir;   v.is = is; v.r1 = r1; v.r2 = r2;
        v.e_aack = ea; v.e_mack = em; v.e_wr = ew; v.e_sel = es; v.e_data = ed;
        v.e_b1 = b1; v.e_b2 = b2; v.e_idle = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.alu_req   = v.ar;  bus.alu_sel = v.as;  bus.alu_data = v.ad;
        bus.mem_req   = v.mr;  bus.mem_sel = v.ms;  bus.mem_data = v.md;
        bus.issue_req = v.ir;  bus.issue_sel = v.is;
        bus.rs1_sel   = v.r1;  bus.rs2_sel = v.r2;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //        rst ar as ad    mr ms md   ir is r1 r2 | aack mack wr sel data b1 b2 idle
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   1, 3, 3, 0,   0, 0, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 111, 0, 0, 0,   0, 0, 3, 0,   1, 0, 0, 0, 0,   1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 3, 0,   0, 0, 1, 3, 111, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 3, 0,   0, 0, 0, 3, 111, 0, 0, 1));
        vecs.push_back(mk(0, 1, 5, 10,  1, 7, 20,  0, 0, 3, 0,   0, 0, 0, 3, 111, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5, 10,  1, 7, 20,  0, 0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(1, 1, 5, 10,  1, 7, 20,  0, 0, 0, 0,   0, 1, 1, 5, 10,  0, 0, 0));
        vecs.push_back(mk(1, 1, 5, 10,  1, 7, 20,  0, 0, 0, 0,   1, 0, 1, 7, 20,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 5, 10,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 99,  0, 0, 0, 0,   0, 1, 0, 5, 10,  0, 0, 1));
        vecs.push_back(mk(1, 1, 8, 1,   1, 9, 2,   0, 0, 0, 0,   1, 0, 0, 0, 99,  0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   1, 4, 0, 4,   0, 0, 1, 8, 1,   0, 0, 0));
        vecs.push_back(mk(1, 1, 4, 44,  0, 0, 0,   0, 0, 0, 4,   1, 0, 0, 8, 1,   0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   1, 4, 0, 4,   0, 0, 1, 4, 44,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 4,   0, 0, 0, 4, 44,  0, 1, 0));
        vecs.push_back(mk(1, 1, 4, 45,  0, 0, 0,   0, 0, 0, 4,   1, 0, 0, 4, 44,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 4,   0, 0, 1, 4, 45,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 4,   0, 0, 0, 4, 45,  0, 0, 1));
        vecs.push_back(mk(1, 1, 9, 90,  0, 0, 0,   1, 2, 2, 9,   1, 0, 0, 4, 45,  0, 0, 1));
        vecs.push_back(mk(1, 1, 10, 100, 0, 0, 0,  1, 9, 2, 9,   1, 0, 1, 9, 90,  1, 0, 0));
        vecs.push_back(mk(0, 1, 11, 110, 1, 12, 120, 0, 0, 2, 9, 0, 0, 1, 10, 100, 1, 1, 0));
        vecs.push_back(mk(1, 1, 11, 110, 1, 12, 120, 0, 0, 2, 9, 1, 0, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,   0, 0, 2, 9,   0, 0, 1, 11, 110, 0, 0, 0));

        // Reset with a pending ALU request: no ack may leak while reset is held.
        drive(mk(0, 1, 1, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("reset_alu_ack", {31'd0, bus.alu_ack}, 32'd0);
        check("reset_mem_ack", {31'd0, bus.mem_ack}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_alu_ack", i), {31'd0, bus.alu_ack}, {31'd0, vecs[i].e_aack});
            check($sformatf("v%0d_mem_ack", i), {31'd0, bus.mem_ack}, {31'd0, vecs[i].e_mack});
            check($sformatf("v%0d_wr_req", i), {31'd0, bus.wr_req}, {31'd0, vecs[i].e_wr});
            check($sformatf("v%0d_wr_sel", i), {27'd0, bus.wr_sel}, {27'd0, vecs[i].e_sel});
            check($sformatf("v%0d_wr_data", i), bus.wr_data, vecs[i].e_data);
            check($sformatf("v%0d_rs1_busy", i), {31'd0, bus.rs1_busy}, {31'd0, vecs[i].e_b1});
            check($sformatf("v%0d_rs2_busy", i), {31'd0, bus.rs2_busy}, {31'd0, vecs[i].e_b2});
            check($sformatf("v%0d_idle", i), {31'd0, bus.idle}, {31'd0, vecs[i].e_idle});
            @(posedge clk);
            #1;
        end

        // Sustained contention: last winner was ALU, so grants go MEM, ALU, MEM, ...
        begin
            logic       exp_alu;
            logic [4:0] exp_sel;
            exp_alu = 1'b0;
            exp_sel = 5'd11;
            drive(mk(1, 1, 13, 130, 1, 14, 140, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                check($sformatf("rr%0d_alu_ack", c), {31'd0, bus.alu_ack}, {31'd0, exp_alu});
                check($sformatf("rr%0d_mem_ack", c), {31'd0, bus.mem_ack}, {31'd0, !exp_alu});
                check($sformatf("rr%0d_wr_sel", c), {27'd0, bus.wr_sel}, {27'd0, exp_sel});
                exp_sel = exp_alu ? 5'd13 : 5'd14;
                exp_alu = !exp_alu;
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
